fifo_sync_flags: RTL and testbench



---
 rtl/fifo_sync_flags.sv | 154 +++++++++++++++
 tb/tb_fifo_sync_flags.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_flags.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_flags
// Description : Single-clock FIFO with power-of-two depth, selectable
//               standard or first-word-fall-through read, fill level with
//               almost-full/almost-empty thresholds, sticky overflow and
//               underflow flags, and a synchronous flush.
// Ports       : CLK_WR       - clock, rising edge
//               RST_WR       - asynchronous reset, active low
//               CLR          - synchronous flush, active high
//               WR_EN/WR_DATA- write request and word
//               RD_EN        - read (standard) or pop (FWFT) request
//               RD_DATA      - read word
//               RD_VALID     - RD_DATA holds a valid word
//               EMPTY/FULL/ALMOST_EMPTY/ALMOST_FULL - level decodes
//               LEVEL        - number of stored words
//               OVERFLOW     - sticky: a write was rejected
//               UNDERFLOW    - sticky: a read was rejected
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_flags #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 2,
    parameter int FWFT       = 0,
    parameter int AFULL_TH   = 3,
    parameter int AEMPTY_TH  = 1
) (
    input  logic                  CLK_WR,
    input  logic                  RST_WR,
    input  logic                  CLR,
    input  logic                  WR_EN,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  RD_EN,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_VALID,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic                  ALMOST_EMPTY,
    output logic                  ALMOST_FULL,
    output logic [ADDR_WIDTH:0]   LEVEL,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int                  c_DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_FULL_LVL   = (ADDR_WIDTH+1)'(c_DEPTH);
    localparam logic [ADDR_WIDTH:0] c_AFULL_LVL  = (ADDR_WIDTH+1)'(AFULL_TH);
    localparam logic [ADDR_WIDTH:0] c_AEMPTY_LVL = (ADDR_WIDTH+1)'(AEMPTY_TH);

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_level;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_empty;
    logic w_full;
    logic w_rd_acc;
    logic w_wr_acc;

    // Flags depend on the level register only, never on the request inputs.
    assign w_empty      = (r_level == '0);
    assign w_full       = (r_level == c_FULL_LVL);
    assign EMPTY        = w_empty;
    assign FULL         = w_full;
    assign ALMOST_EMPTY = (r_level <= c_AEMPTY_LVL);
    assign ALMOST_FULL  = (r_level >= c_AFULL_LVL);
    assign LEVEL        = r_level;
    assign OVERFLOW     = r_overflow;
    assign UNDERFLOW    = r_underflow;

    // A flush swallows both requests. At full, a simultaneous accepted read
    // frees a slot so the write is still taken.
    assign w_rd_acc = !CLR && RD_EN && !w_empty;
    assign w_wr_acc = !CLR && WR_EN && (!w_full || w_rd_acc);

    // Storage: cleared only by reset, never by flush.
    always_ff @(posedge CLK_WR or negedge RST_WR) begin
        if (!RST_WR) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_acc) begin
            r_mem[r_wptr] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK_WR or negedge RST_WR) begin
        if (!RST_WR) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (CLR) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (WR_EN && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end
            // Includes read+write at empty: the write lands, the read does not.
            if (RD_EN && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is always presented; RD_EN only pops it.
            assign RD_DATA  = r_mem[r_rptr];
            assign RD_VALID = !w_empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_rd_data;
            logic                  r_rd_valid;

            always_ff @(posedge CLK_WR or negedge RST_WR) begin
                if (!RST_WR) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else if (CLR) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_rd_data <= r_mem[r_rptr];
                    end
                end
            end

            assign RD_DATA  = r_rd_data;
            assign RD_VALID = r_rd_valid;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_flags.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_sync_flags
// Description : Self-checking bench for fifo_sync_flags. A standard-mode and
//               an FWFT-mode instance share one stimulus stream and are both
//               compared against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_flags;

    localparam int c_DW = 8;
    localparam int c_AW = 2;
    localparam int c_DEPTH = 4;
    localparam int c_AFULL = 3;
    localparam int c_AEMPTY = 1;

    logic            clk;
    logic            rst_n;
    logic            r_clr;
    logic            r_wr_en;
    logic [c_DW-1:0] r_wr_data;
    logic            r_rd_en;

    logic [c_DW-1:0] w_s_rd_data, w_f_rd_data;
    logic            w_s_rd_valid, w_f_rd_valid;
    logic            w_s_empty, w_f_empty, w_s_full, w_f_full;
    logic            w_s_aempty, w_f_aempty, w_s_afull, w_f_afull;
    logic [c_AW:0]   w_s_level, w_f_level;
    logic            w_s_ovf, w_f_ovf, w_s_udf, w_f_udf;

    fifo_sync_flags #(
        .DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW), .FWFT(0),
        .AFULL_TH(c_AFULL), .AEMPTY_TH(c_AEMPTY)
    ) u_std (
        .CLK_WR(clk), .RST_WR(rst_n), .CLR(r_clr),
        .WR_EN(r_wr_en), .WR_DATA(r_wr_data), .RD_EN(r_rd_en),
        .RD_DATA(w_s_rd_data), .RD_VALID(w_s_rd_valid),
        .EMPTY(w_s_empty), .FULL(w_s_full),
        .ALMOST_EMPTY(w_s_aempty), .ALMOST_FULL(w_s_afull),
        .LEVEL(w_s_level), .OVERFLOW(w_s_ovf), .UNDERFLOW(w_s_udf)
    );

    fifo_sync_flags #(
        .DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW), .FWFT(1),
        .AFULL_TH(c_AFULL), .AEMPTY_TH(c_AEMPTY)
    ) u_fwft (
        .CLK_WR(clk), .RST_WR(rst_n), .CLR(r_clr),
        .WR_EN(r_wr_en), .WR_DATA(r_wr_data), .RD_EN(r_rd_en),
        .RD_DATA(w_f_rd_data), .RD_VALID(w_f_rd_valid),
        .EMPTY(w_f_empty), .FULL(w_f_full),
        .ALMOST_EMPTY(w_f_aempty), .ALMOST_FULL(w_f_afull),
        .LEVEL(w_f_level), .OVERFLOW(w_f_ovf), .UNDERFLOW(w_f_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: a plain queue of words plus the observable flags.
    // ------------------------------------------------------------------
    logic [c_DW-1:0] m_q[$];
    logic            m_ovf;
    logic            m_udf;
    logic            m_s_valid;
    logic [c_DW-1:0] m_s_data;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf     = 1'b0;
        m_udf     = 1'b0;
        m_s_valid = 1'b0;
        m_s_data  = '0;
    endtask

    task automatic model_step(input logic clr, input logic we, input logic [c_DW-1:0] wd,
                              input logic re);
        int  n;
        logic rd, wr;
        if (clr) begin
            m_q.delete();
            m_ovf     = 1'b0;
            m_udf     = 1'b0;
            m_s_valid = 1'b0;
            m_s_data  = '0;
        end else begin
            n  = m_q.size();
            rd = re && (n != 0);
            wr = we && ((n < c_DEPTH) || rd);
            if (we && !wr) m_ovf = 1'b1;
            if (re && (n == 0)) m_udf = 1'b1;
            m_s_valid = rd;
            if (rd) m_s_data = m_q.pop_front();
            if (wr) m_q.push_back(wd);
        end
    endtask

    task automatic check_all();
        int n;
        n = m_q.size();
        check("s_level",  32'(w_s_level),  32'(n));
        check("f_level",  32'(w_f_level),  32'(n));
        check("s_empty",  32'(w_s_empty),  32'(n == 0));
        check("f_empty",  32'(w_f_empty),  32'(n == 0));
        check("s_full",   32'(w_s_full),   32'(n == c_DEPTH));
        check("f_full",   32'(w_f_full),   32'(n == c_DEPTH));
        check("s_aempty", 32'(w_s_aempty), 32'(n <= c_AEMPTY));
        check("f_aempty", 32'(w_f_aempty), 32'(n <= c_AEMPTY));
        check("s_afull",  32'(w_s_afull),  32'(n >= c_AFULL));
        check("f_afull",  32'(w_f_afull),  32'(n >= c_AFULL));
        check("s_ovf",    32'(w_s_ovf),    32'(m_ovf));
        check("f_ovf",    32'(w_f_ovf),    32'(m_ovf));
        check("s_udf",    32'(w_s_udf),    32'(m_udf));
        check("f_udf",    32'(w_f_udf),    32'(m_udf));
        check("s_rd_valid", 32'(w_s_rd_valid), 32'(m_s_valid));
        check("s_rd_data",  32'(w_s_rd_data),  32'(m_s_data));
        check("f_rd_valid", 32'(w_f_rd_valid), 32'(n != 0));
        // When empty the FWFT output shows stale storage, so only the head is checked.
        if (n != 0) check("f_rd_data", 32'(w_f_rd_data), 32'(m_q[0]));
    endtask

    // Apply one cycle of requests, advance the model at the edge, then sample.
    task automatic drive(input logic clr, input logic we, input logic [c_DW-1:0] wd,
                         input logic re);
        r_clr     = clr;
        r_wr_en   = we;
        r_wr_data = wd;
        r_rd_en   = re;
        @(posedge clk);
        model_step(clr, we, wd, re);
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0;
        r_clr = 1'b0; r_wr_en = 1'b0; r_wr_data = '0; r_rd_en = 1'b0;
        model_reset();
        #12;
        check_all();
        check("f_rd_data_rst", 32'(w_f_rd_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill, overflow attempt, full read+write, drain past empty.
        drive(0, 1, 8'h11, 0);
        drive(0, 1, 8'h22, 0);
        drive(0, 1, 8'h33, 0);
        drive(0, 1, 8'h44, 0);
        drive(0, 1, 8'h55, 0);
        drive(0, 1, 8'h55, 1);
        for (int i = 0; i < 5; i++) drive(0, 0, 8'h00, 1);
        drive(0, 0, 8'h00, 0);

        // Read+write at empty, then read the word back.
        drive(0, 1, 8'hA5, 1);
        drive(0, 0, 8'h00, 1);
        drive(0, 0, 8'h00, 0);

        // FWFT presentation: single write, idle, pop.
        drive(0, 1, 8'h3C, 0);
        drive(0, 0, 8'h00, 0);
        drive(0, 0, 8'h00, 1);

        // Flush with a pending write while overflowed at level 3.
        for (int i = 0; i < 5; i++) drive(0, 1, 8'(8'h60 + i), 0);
        drive(0, 0, 8'h00, 1);
        drive(1, 1, 8'hEE, 1);
        drive(0, 0, 8'h00, 0);

        // Asynchronous reset in the middle of a transfer.
        drive(0, 1, 8'h71, 0);
        drive(0, 1, 8'h72, 1);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("f_rd_data_mid_rst", 32'(w_f_rd_data), 32'h0);
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic with shifting write/read bias.
        for (int ph = 0; ph < 6; ph++) begin
            int pw, pr;
            pw = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
            pr = 100 - pw;
            for (int i = 0; i < 80; i++) begin
                drive(($urandom_range(0, 99) < 3),
                      ($urandom_range(0, 99) < pw),
                      8'($urandom),
                      ($urandom_range(0, 99) < pr));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
